// File: rtl/debounce_sync_if.sv
// ============================================================================
// Module   : debounce_sync_if
// Brief    : Signal bundle between a raw level source and debounce_sync.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface debounce_sync_if;
  logic din;
  logic dout;
  logic rise;
  logic fall;
  logic busy;

  // Source side drives the raw level and observes the conditioned outputs.
  modport master (
    output din,
    input  dout,
    input  rise,
    input  fall,
    input  busy
  );

  modport slave (
    input  din,
    output dout,
    output rise,
    output fall,
    output busy
  );
endinterface

`default_nettype wire

// File: rtl/debounce_sync.sv
// ============================================================================
// Module   : debounce_sync
// Brief    : 2-flop synchronizer + stability counter + IDLE/QUAL FSM producing a
//            clean level; edge pulses built only with DEBOUNCE_SYNC_EDGE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module debounce_sync #(
  parameter int   STABLE_CYCLES = 4,
  parameter logic RESET_VAL     = 1'b0
) (
  input  wire logic      clk,
  input  wire logic      rst,
  debounce_sync_if.slave bus
);

  localparam int                 c_CNT_W    = $clog2(STABLE_CYCLES + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(STABLE_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_QUAL = 1'b1
  } state_t;

  logic               r_sync1;
  logic               r_sync2;
  logic               r_dout;
  logic               r_busy;
  logic [c_CNT_W-1:0] r_cnt;
  state_t             r_state;

  logic [c_CNT_W-1:0] w_cnt_nxt;
  logic               w_dout_nxt;
  state_t             w_state_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= RESET_VAL;
      r_sync2 <= RESET_VAL;
      r_dout  <= RESET_VAL;
      r_busy  <= 1'b0;
      r_cnt   <= '0;
      r_state <= S_IDLE;
    end else begin
      r_sync1 <= bus.din;
      r_sync2 <= r_sync1;
      r_dout  <= w_dout_nxt;
      r_busy  <= (w_state_nxt == S_QUAL);
      r_cnt   <= w_cnt_nxt;
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_dout_nxt  = r_dout;
    case (r_state)
      S_IDLE: begin
        if (r_sync2 != r_dout) begin
          // A single qualifying sample is enough, so no QUAL visit is needed.
          if (STABLE_CYCLES == 1) begin
            w_dout_nxt = r_sync2;
            w_cnt_nxt  = '0;
          end else begin
            w_state_nxt = S_QUAL;
            w_cnt_nxt   = c_CNT_ONE;
          end
        end else begin
          w_cnt_nxt = '0;
        end
      end
      S_QUAL: begin
        if (r_sync2 == r_dout) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == c_CNT_LAST) begin
          w_dout_nxt  = r_sync2;
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + c_CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign bus.dout = r_dout;
  assign bus.busy = r_busy;

`ifdef DEBOUNCE_SYNC_EDGE_EN
  logic r_rise;
  logic r_fall;

  // Pulses follow the committed level change, so reset never creates one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_rise <= w_dout_nxt & ~r_dout;
      r_fall <= ~w_dout_nxt & r_dout;
    end
  end

  assign bus.rise = r_rise;
  assign bus.fall = r_fall;
`else
  assign bus.rise = 1'b0;
  assign bus.fall = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_debounce_sync.sv
// ============================================================================
// Module   : tb_debounce_sync
// Brief    : Directed scoreboard bench for debounce_sync (STABLE_CYCLES=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_debounce_sync;

  logic clk;
  logic rst;

  debounce_sync_if bus ();

  debounce_sync #(
    .STABLE_CYCLES (4),
    .RESET_VAL     (1'b0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [3:0] exp;   // {dout, rise, fall, busy}
    int         idx;
  } item_t;

  item_t sb_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    vec_idx = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Inputs change 2 time units after a rising edge; the expectation describes
  // the outputs seen at the following falling edge.
  task automatic step(input logic r, input logic d, input logic [3:0] e);
    item_t it;
    @(posedge clk);
    #2;
    rst     = r;
    bus.din = d;
`ifndef DEBOUNCE_SYNC_EDGE_EN
    e[2:1] = 2'b00;
`endif
    it.exp = e;
    it.idx = vec_idx;
    vec_idx++;
    sb_q.push_back(it);
  endtask

  task automatic hold(input int n, input logic d, input logic [3:0] e);
    for (int i = 0; i < n; i++) step(1'b0, d, e);
  endtask

  // din change at vector j: busy at j+3..j+5, new level + pulse at j+6.
  task automatic clean_rise();
    hold(3, 1'b1, 4'b0000);
    hold(3, 1'b1, 4'b0001);
    hold(1, 1'b1, 4'b1100);
    hold(2, 1'b1, 4'b1000);
  endtask

  task automatic clean_fall();
    hold(3, 1'b0, 4'b1000);
    hold(3, 1'b0, 4'b1001);
    hold(1, 1'b0, 4'b0010);
    hold(2, 1'b0, 4'b0000);
  endtask

  initial begin : monitor
    item_t      it;
    logic [3:0] act;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        it  = sb_q.pop_front();
        act = {bus.dout, bus.rise, bus.fall, bus.busy};
        n_tests++;
        if (act !== it.exp) begin
          n_fail++;
          $display("FAIL vec%0d dout/rise/fall/busy actual=%b expected=%b",
                   it.idx, act, it.exp);
        end
      end
    end
  end

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    rst     = 1'b1;
    bus.din = 1'b1;

    // Reset hold with din=1, then release: no pulse, normal qualification.
    step(1'b1, 1'b1, 4'b0000);
    step(1'b1, 1'b1, 4'b0000);
    clean_rise();

    clean_fall();

    // 2-sample glitch rejected.
    hold(2, 1'b1, 4'b0000);
    hold(1, 1'b0, 4'b0000);
    hold(2, 1'b0, 4'b0001);
    hold(3, 1'b0, 4'b0000);

    // 3-sample glitch (one short of STABLE_CYCLES) rejected.
    hold(3, 1'b1, 4'b0000);
    hold(3, 1'b0, 4'b0001);
    hold(3, 1'b0, 4'b0000);

    // Reset mid-qualification of a rise clears busy before the next edge.
    hold(3, 1'b1, 4'b0000);
    hold(1, 1'b1, 4'b0001);
    step(1'b1, 1'b1, 4'b0000);
    step(1'b1, 1'b1, 4'b0000);
    clean_rise();

    // Reset mid-qualification of a fall drops dout asynchronously, no pulse.
    hold(3, 1'b0, 4'b1000);
    hold(1, 1'b0, 4'b1001);
    step(1'b1, 1'b0, 4'b0000);
    hold(6, 1'b0, 4'b0000);

    clean_rise();
    clean_fall();

    @(negedge clk);
    #1;
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
